// File: rtl/sme_pkg.sv
// sme_pkg: metacharacter codes, FSM states and index-width helper for sme_param
package sme_pkg;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE} state_t;
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sme_char_cmp.sv
// sme_char_cmp: one string/pattern char compare with '.' wildcard; SME_CASE_FOLD_EN folds ASCII letter case
module sme_char_cmp import sme_pkg::*; #(
  parameter int CHAR_W = 8
) (
  input  logic [CHAR_W-1:0] s_ch,
  input  logic [CHAR_W-1:0] p_ch,
  output logic              eq
);
`ifdef SME_CASE_FOLD_EN
  function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c);
    return (c >= CHAR_W'(8'h41) && c <= CHAR_W'(8'h5A)) ? (c | CHAR_W'(8'h20)) : c;
  endfunction
  assign eq = (p_ch == CHAR_W'(CH_DOT)) || (fold(s_ch) == fold(p_ch));
`else
  assign eq = (p_ch == CHAR_W'(CH_DOT)) || (s_ch == p_ch);
`endif
endmodule

// File: rtl/sme_param.sv
// sme_param: parametrised string matcher with . ^ $ * metachars; optional SME_CASE_FOLD_EN case folding
module sme_param import sme_pkg::*; #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int CHAR_W  = 8,
  parameter int IDX_W   = idx_w(STR_MAX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index,
  output logic              busy
);
  localparam int PW = idx_w(PAT_MAX);
  localparam logic [IDX_W-1:0] SMAX = IDX_W'(STR_MAX);
  localparam logic [PW-1:0] PMAX = PW'(PAT_MAX);
  localparam logic [IDX_W-1:0] S1 = IDX_W'(1);
  localparam logic [PW-1:0] P1 = PW'(1);
  state_t state;
  logic [CHAR_W-1:0] str_buf [STR_MAX+1];
  logic [CHAR_W-1:0] pat_buf [PAT_MAX+1];
  logic [IDX_W-1:0] str_len, s, si, star_si, str_wa;
  logic [PW-1:0] pat_len, pi, star_pi, pat_wa;
  logic star_on, loading, str_we, pat_start, pat_we, eq;
  logic [CHAR_W-1:0] s_ch, p_ch, prev_ch;
  logic pat_done, is_star, is_caret, is_dollar, at_end, step_ok, star_more, last_cand;
  assign loading   = state == IDLE || state == DONE || state == LOAD_STR;
  assign str_wa    = state == LOAD_STR ? str_len : '0;
  assign str_we    = loading && isstring && str_wa < SMAX;
  assign pat_start = loading && ispattern && !isstring;
  assign pat_wa    = pat_start ? '0 : pat_len;
  assign pat_we    = pat_start || (state == LOAD_PAT && ispattern && !isstring && pat_len < PMAX);
  assign s_ch      = str_buf[si];
  assign p_ch      = pat_buf[pi];
  assign prev_ch   = str_buf[si - S1];
  assign pat_done  = pi == pat_len;
  assign is_star   = p_ch == CHAR_W'(CH_STAR);
  assign is_caret  = p_ch == CHAR_W'(CH_CARET);
  assign is_dollar = p_ch == CHAR_W'(CH_DOLLAR);
  assign at_end    = si == str_len;
  // anchors test a position without consuming; ordinary chars need a char to compare against
  assign step_ok   = is_caret  ? (si == '0 || prev_ch == CHAR_W'(CH_SPACE)) :
                     is_dollar ? (at_end || s_ch == CHAR_W'(CH_SPACE)) :
                                 (!at_end && eq);
  assign star_more = star_on && star_si != str_len;
  assign last_cand = s == str_len;
  sme_char_cmp #(.CHAR_W(CHAR_W)) u_cmp (.s_ch(s_ch), .p_ch(p_ch), .eq(eq));
  always_ff @(posedge clk) begin
    if (str_we) str_buf[str_wa] <= chardata;
    if (pat_we) pat_buf[pat_wa] <= chardata;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      str_len     <= '0;
      pat_len     <= '0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
      busy        <= 1'b0;
      s           <= '0;
      si          <= '0;
      pi          <= '0;
      star_si     <= '0;
      star_pi     <= '0;
      star_on     <= 1'b0;
    end else if (loading) begin
      valid <= 1'b0;
      if (isstring) begin
        state   <= LOAD_STR;
        str_len <= str_wa + IDX_W'(str_wa < SMAX);
      end else if (ispattern) begin
        state   <= LOAD_PAT;
        pat_len <= P1;
        busy    <= 1'b1;
      end else
        state <= IDLE;
    end else if (state == LOAD_PAT) begin
      if (!ispattern) begin
        state   <= SEARCH;
        s       <= '0;
        si      <= '0;
        pi      <= '0;
        star_on <= 1'b0;
      end else if (!isstring)
        pat_len <= pat_len + PW'(pat_len < PMAX);
    end else begin
      if (pat_done) begin
        state       <= DONE;
        valid       <= 1'b1;
        match       <= 1'b1;
        match_index <= s;
        busy        <= 1'b0;
      end else if (is_star) begin
        star_on <= 1'b1;
        star_pi <= pi + P1;
        star_si <= si;
        pi      <= pi + P1;
      end else if (step_ok) begin
        pi <= pi + P1;
        si <= (is_caret || is_dollar) ? si : si + S1;
      end else if (star_more) begin
        star_si <= star_si + S1;
        si      <= star_si + S1;
        pi      <= star_pi;
      end else if (last_cand) begin
        state       <= DONE;
        valid       <= 1'b1;
        match       <= 1'b0;
        match_index <= '0;
        busy        <= 1'b0;
      end else begin
        s       <= s + S1;
        si      <= s + S1;
        pi      <= '0;
        star_on <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sme_param.sv
// tb_sme_param: directed checks of sme_param matching, anchors, stars, saturation and reset abort
module tb_sme_param;
  logic clk, reset, isstring, ispattern;
  logic [7:0] chardata;
  logic valid, match, busy;
  logic [5:0] match_index;
  int total = 0, passed = 0;
  sme_param dut (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .valid(valid), .match(match), .match_index(match_index), .busy(busy)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic send(input string st, input string pt);
    for (int i = 0; i < st.len(); i++) begin
      @(negedge clk);
      isstring = 1; ispattern = 0; chardata = st[i];
    end
    for (int i = 0; i < pt.len(); i++) begin
      @(negedge clk);
      isstring = 0; ispattern = 1; chardata = pt[i];
    end
    @(negedge clk);
    isstring = 0; ispattern = 0;
  endtask
  task automatic run(input string tag, input string st, input string pt, input logic em, input int ei);
    int n = 0;
    logic got = 0;
    send(st, pt);
    while (n < 1000 && !got) begin
      @(posedge clk);
      #1;
      got = valid;
      n++;
    end
    check({tag, "_valid"}, got, 1);
    check({tag, "_match"}, match, em);
    check({tag, "_index"}, match_index, ei);
    check({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    int pulses;
    reset = 1; isstring = 0; ispattern = 0; chardata = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_match", match, 0);
    check("rst_index", match_index, 0);
    check("rst_busy", busy, 0);
    reset = 0;
    run("empty_anchor", "", "^$", 1, 0);
    run("empty_char", "", "a", 0, 0);
    run("wor", "hello world", "wor", 1, 6);
    run("caret_dot", "", "^w.r", 1, 6);
    run("caret_miss", "", "^orl", 0, 0);
    run("two_stars", "", "h*o*d", 1, 0);
    run("dollar_sp", "abc def", "c$", 1, 2);
    run("dollar_end", "", "f$", 1, 6);
    run("star_hit", "abcxxdef", "b*d", 1, 1);
    run("star_miss", "", "b*z", 0, 0);
    run("sat_drop", "0123456789:;<=>?@ABCDEFGHIJKLMNOPQRSTUVW", "OP", 0, 0);
    run("sat_30", "", "NO", 1, 30);
    run("sat_end", "", "O$", 1, 31);
    send("hello world", "zzz");
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    @(negedge clk);
    reset = 1;
    #1;
    check("abort_valid", valid, 0);
    check("abort_match", match, 0);
    check("abort_index", match_index, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    reset = 0;
    pulses = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
    end
    check("abort_nopulse", pulses, 0);
`ifdef SME_CASE_FOLD_EN
    run("fold", "AbC", "abc", 1, 0);
`else
    run("fold", "AbC", "abc", 0, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
